// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported memory between instruction fetch and
// the data (load/store) stage. One transaction is in flight at a time. Data
// wins by default, and a streak limit keeps fetch from being starved.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    // fetch side
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRdata,
    output logic          IValid,
    output logic          IStall,
    // data side
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWdata,
    output logic [DW-1:0] DRdata,
    output logic          DValid,
    output logic          DStall,
    // memory side
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemReady
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t        state, stateNext;
    logic [SW-1:0] streak;
    logic          dWins;
    logic          grantD;
    logic          grantI;
    logic          doneI;
    logic          doneD;

    // Next-state and grant decode. When data wins arbitration but its Valid
    // pulse is showing, the slot is left empty rather than handed to fetch,
    // so a continuously renewing data stream counts up its streak.
    always_comb begin
        stateNext = state;
        grantD    = 1'b0;
        grantI    = 1'b0;
        doneI     = 1'b0;
        doneD     = 1'b0;
        dWins     = DReq && (!IReq || (streak < STREAK_MAX));
        case (state)
            IDLE: begin
                if (dWins) begin
                    if (!DValid) begin
                        grantD    = 1'b1;
                        stateNext = GRANT_D;
                    end
                end else if (IReq && !IValid) begin
                    grantI    = 1'b1;
                    stateNext = GRANT_I;
                end
            end
            GRANT_I: begin
                if (MemReady) begin
                    doneI     = 1'b1;
                    stateNext = IDLE;
                end
            end
            GRANT_D: begin
                if (MemReady) begin
                    doneD     = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // A request is outstanding exactly while a grant state is held.
    assign MemReq = (state != IDLE);

    // Latch the winning requester's address, write enable and store data.
    always_ff @(posedge clk) begin
        if (reset) begin
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
        end else if (grantD) begin
            MemWe    <= DWe;
            MemAddr  <= DAddr;
            MemWdata <= DWdata;
        end else if (grantI) begin
            MemWe    <= 1'b0;
            MemAddr  <= IAddr;
            MemWdata <= '0;
        end
    end

    // Completion: one-cycle Valid pulse, read data captured for loads/fetches.
    always_ff @(posedge clk) begin
        if (reset) begin
            IValid <= 1'b0;
            DValid <= 1'b0;
            IRdata <= '0;
            DRdata <= '0;
        end else begin
            IValid <= doneI;
            DValid <= doneD;
            if (doneI)           IRdata <= MemRdata;
            if (doneD && !MemWe) DRdata <= MemRdata;
        end
    end

    // Consecutive data grants made while fetch waits; saturating.
    always_ff @(posedge clk) begin
        if (reset)                                streak <= '0;
        else if (!IReq || grantI)                 streak <= '0;
        else if (grantD && (streak < STREAK_MAX)) streak <= streak + SW'(1);
    end

    assign IStall = IReq & ~IValid;
    assign DStall = DReq & ~DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: queue-driven requesters, a
// latency-programmable memory, and a transaction-level monitor.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic          clk = 1'b0;
    logic          reset;
    logic          IReq, IValid, IStall;
    logic [AW-1:0] IAddr;
    logic [DW-1:0] IRdata;
    logic          DReq, DWe, DValid, DStall;
    logic [AW-1:0] DAddr;
    logic [DW-1:0] DWdata, DRdata;
    logic          MemReq, MemWe, MemReady;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWdata, MemRdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid), .IStall(IStall),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata),
        .DValid(DValid), .DStall(DStall),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemReady(MemReady)
    );

    typedef struct packed {
        logic          isD;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    int errors = 0;
    int checks = 0;

    txn_t txq[$];           // expected memory transactions, in grant order
    txn_t dq[$], iq[$];     // pending requests per requester
    logic [31:0] memArr [logic [31:0]];
    int memLat = 1;
    int memCnt = 0;
    int cyc = 0;
    int iLat = 0, dLat = 0, iStart = 0, dStart = 0;
    logic [15:0] glog;      // owner of each Valid pulse seen, 1 = data

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function logic [31:0] rd(logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // One cycle: memory model response and requester behaviour, at negedge.
    task step();
        @(negedge clk);
        cyc++;
        if (MemReq === 1'b1) begin
            memCnt++;
            if (memCnt == memLat) begin
                MemReady = 1'b1;
                if (MemWe) begin
                    memArr[MemAddr] = MemWdata;
                    MemRdata = BAD;
                end else begin
                    MemRdata = rd(MemAddr);
                end
            end else begin
                MemReady = 1'b0;
                MemRdata = BAD;
            end
        end else begin
            memCnt   = 0;
            MemReady = 1'b0;
            MemRdata = BAD;
        end
        if (DReq && DValid) begin
            dLat = cyc - dStart;
            void'(dq.pop_front());
            dStart = cyc;
        end else if (!DReq) dStart = cyc;
        if (dq.size() > 0) begin
            DReq = 1'b1; DWe = dq[0].we; DAddr = dq[0].addr; DWdata = dq[0].wdata;
        end else DReq = 1'b0;
        if (IReq && IValid) begin
            iLat = cyc - iStart;
            void'(iq.pop_front());
            iStart = cyc;
        end else if (!IReq) iStart = cyc;
        if (iq.size() > 0) begin
            IReq = 1'b1; IAddr = iq[0].addr;
        end else IReq = 1'b0;
    endtask

    task runDone(input int maxCyc, input string name);
        int n;
        n = 0;
        while (!(dq.size() == 0 && iq.size() == 0 && !DReq && !IReq &&
                 MemReq === 1'b0 && txq.size() == 0) && n < maxCyc) begin
            step();
            n++;
        end
        checks++;
        if (n >= maxCyc) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
        repeat (2) step();
    endtask

    // Monitor: checks the port against the transaction model every cycle.
    logic hs, hsWe, rstS, prevReq;
    logic [31:0] hsData, expI, expD;
    txn_t cur;

    always @(posedge clk) begin
        hs     = (MemReq === 1'b1) && (MemReady === 1'b1);
        hsWe   = MemWe;
        hsData = MemRdata;
        rstS   = reset;
        #1;
        if (rstS) begin
            chk("rst_MemReq", MemReq, 0);
            chk("rst_MemWe", MemWe, 0);
            chk("rst_MemAddr", MemAddr, 0);
            chk("rst_MemWdata", MemWdata, 0);
            chk("rst_IRdata", IRdata, 0);
            chk("rst_DRdata", DRdata, 0);
            chk("rst_IValid", IValid, 0);
            chk("rst_DValid", DValid, 0);
            expI = '0;
            expD = '0;
            txq.delete();
        end else begin
            chk("IValid", IValid, hs && !cur.isD);
            chk("DValid", DValid, hs && cur.isD);
            if (hs && !cur.isD)            expI = hsData;
            if (hs && cur.isD && !hsWe)    expD = hsData;
            chk("IRdata", IRdata, expI);
            chk("DRdata", DRdata, expD);
            chk("IStall", IStall, IReq && !IValid);
            chk("DStall", DStall, DReq && !DValid);
            if (IValid === 1'b1 || DValid === 1'b1) glog = {glog[14:0], DValid};
            if (hs) chk("MemReq_drop", MemReq, 0);
            else if (MemReq === 1'b1 && prevReq === 1'b1) begin
                chk("hold_MemAddr", MemAddr, cur.addr);
                chk("hold_MemWe", MemWe, cur.we);
                if (cur.isD) chk("hold_MemWdata", MemWdata, cur.wdata);
            end
            if (MemReq === 1'b1 && prevReq !== 1'b1 && !hs) begin
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: got addr %h, required no transaction", MemAddr);
                end else begin
                    cur = txq.pop_front();
                    chk("txn_MemAddr", MemAddr, cur.addr);
                    chk("txn_MemWe", MemWe, cur.we);
                    if (cur.isD) chk("txn_MemWdata", MemWdata, cur.wdata);
                end
            end
        end
        prevReq = MemReq;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        IReq = 0; IAddr = 0; DReq = 0; DWe = 0; DAddr = 0; DWdata = 0;
        MemReady = 0; MemRdata = BAD;
        glog = '0; expI = '0; expD = '0; cur = '0; prevReq = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Fetch only, memory ready on the third MemReq cycle.
        memArr[32'h8] = 32'hE3A01005;
        memLat = 3;
        iq.push_back('{1'b0, 1'b0, 32'h8, 32'h0});
        txq.push_back('{1'b0, 1'b0, 32'h8, 32'h0});
        runDone(60, "fetch");
        chk("fetch_latency", iLat, 4);
        chk("fetch_IRdata", IRdata, 32'hE3A01005);

        // Simultaneous store and fetch: data first.
        memLat = 2;
        glog = '0;
        dq.push_back('{1'b1, 1'b1, 32'h100, 32'hDEADBEEF});
        iq.push_back('{1'b0, 1'b0, 32'h10, 32'h0});
        txq.push_back('{1'b1, 1'b1, 32'h100, 32'hDEADBEEF});
        txq.push_back('{1'b0, 1'b0, 32'h10, 32'h0});
        runDone(60, "simul");
        chk("simul_order", glog[1:0], 2'b10);
        chk("simul_store", memArr[32'h100], 32'hDEADBEEF);

        // Load with single-cycle memory, then a store that must not touch DRdata.
        memArr[32'h200] = 32'h12345678;
        memLat = 1;
        dq.push_back('{1'b1, 1'b0, 32'h200, 32'h0});
        txq.push_back('{1'b1, 1'b0, 32'h200, 32'h0});
        runDone(40, "load");
        chk("load_latency", dLat, 2);
        chk("load_DRdata", DRdata, 32'h12345678);
        dq.push_back('{1'b1, 1'b1, 32'h204, 32'hCAFEF00D});
        txq.push_back('{1'b1, 1'b1, 32'h204, 32'hCAFEF00D});
        runDone(40, "store");
        chk("store_keeps_DRdata", DRdata, 32'h12345678);
        chk("store_mem", memArr[32'h204], 32'hCAFEF00D);

        // Starvation: six back-to-back loads against one fetch.
        glog = '0;
        for (int i = 0; i < 6; i++)
            dq.push_back('{1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0});
        iq.push_back('{1'b0, 1'b0, 32'h40, 32'h0});
        for (int i = 0; i < 4; i++)
            txq.push_back('{1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0});
        txq.push_back('{1'b0, 1'b0, 32'h40, 32'h0});
        for (int i = 4; i < 6; i++)
            txq.push_back('{1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0});
        runDone(200, "starve");
        chk("starve_order", glog[6:0], 7'b1111011);

        // Memory completes on the eleventh MemReq cycle.
        memLat = 11;
        dq.push_back('{1'b1, 1'b0, 32'h400, 32'h0});
        txq.push_back('{1'b1, 1'b0, 32'h400, 32'h0});
        runDone(100, "delay");
        chk("delay_latency", dLat, 12);
        chk("delay_DRdata", DRdata, 32'h400 ^ 32'hA5A5_0000);

        // Reset in the middle of a data grant.
        memLat = 1000;
        dq.push_back('{1'b1, 1'b1, 32'h500, 32'h55AA55AA});
        txq.push_back('{1'b1, 1'b1, 32'h500, 32'h55AA55AA});
        for (int i = 0; i < 10 && MemReq !== 1'b1; i++) step();
        chk("midop_MemReq_up", MemReq, 1);
        repeat (2) step();
        reset = 1'b1;
        dq.delete();
        DReq = 1'b0;
        step();
        chk("midop_MemReq", MemReq, 0);
        chk("midop_DValid", DValid, 0);
        chk("midop_DRdata", DRdata, 0);
        chk("midop_IRdata", IRdata, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_DValid", DValid, 0);
            chk("post_rst_MemReq", MemReq, 0);
        end
        chk("midop_no_write", memArr.exists(32'h500), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
